// File: rtl/segment_select_seq.sv
// segment_select_seq: registered weighted segment selector.
// Splits the signed range [MIN,MAX] into up to three typed segments from the
// request bounds, then draws one segment by weight using an internal Galois
// LFSR with bounded rejection sampling and a sequential cumulative scan.
module segment_select_seq #(
    parameter int WIDTH      = 8,
    parameter int LFSR_WIDTH = 16,
    parameter int EXP_WEIGHT = 2,
    parameter int MAX_RETRY  = 3
) (
    input  logic                  in_clock,
    input  logic                  in_reset,
    input  logic [LFSR_WIDTH-1:0] in_seed,
    input  logic                  in_start_valid,
    output logic                  out_start_ready,
    input  logic [WIDTH-1:0]      in_c_less_than,
    input  logic [WIDTH-1:0]      in_c_more_than,
    input  logic [1:0]            in_flag,
    output logic                  out_valid,
    input  logic                  in_result_ready,
    output logic [1:0]            out_segment_index,
    output logic [1:0]            out_segment_type,
    output logic [WIDTH-1:0]      out_segment_from,
    output logic [WIDTH-1:0]      out_segment_to,
    output logic [WIDTH+1:0]      out_segment_weight,
    output logic [WIDTH+1:0]      out_total_weight
);
    localparam int W2 = WIDTH + 2;
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [LFSR_WIDTH-1:0] TAPS = LFSR_WIDTH'(16'hB400);
    localparam logic [1:0] T_EXPDOWN = 2'd1;
    localparam logic [1:0] T_EXPUP   = 2'd2;
    localparam logic [1:0] T_UNI     = 2'd3;
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [W2-1:0] EW = W2'(EXP_WEIGHT);
    localparam logic [W2-1:0] ONE = W2'(1);

    typedef enum logic [2:0] {IDLE, BUILD, DRAW, SCAN, DONE} state_t;

    state_t                    state;
    logic [WIDTH-1:0]          cl_q, cm_q;
    logic [1:0]                flag_q;
    logic [LFSR_WIDTH-1:0]     lfsr, lfsr_next;
    logic [2:0][1:0]           typ_q, b_typ;
    logic [2:0][WIDTH-1:0]     from_q, to_q, b_from, b_to;
    logic [2:0][W2-1:0]        w_q, b_w;
    logic [W2-1:0]             total_q, mask_q, b_total, b_mask;
    logic [W2-1:0]             r_q, r_draw, cum_q, cum_next;
    logic [RW-1:0]             retry_q;
    logic [1:0]                idx_q;

    // Bounds sign-extended so weight differences cannot overflow
    logic signed [W2-1:0]      cl_x, cm_x, min_x, max_x;
    logic signed [WIDTH:0]     mid_sum, mid_sh;
    logic [WIDTH-1:0]          mid;

    assign cl_x    = {{2{cl_q[WIDTH-1]}}, cl_q};
    assign cm_x    = {{2{cm_q[WIDTH-1]}}, cm_q};
    assign min_x   = {{2{MIN_V[WIDTH-1]}}, MIN_V};
    assign max_x   = {{2{MAX_V[WIDTH-1]}}, MAX_V};
    assign mid_sum = $signed({cl_q[WIDTH-1], cl_q}) + $signed({cm_q[WIDTH-1], cm_q});
    assign mid_sh  = mid_sum >>> 1;
    assign mid     = mid_sh[WIDTH-1:0];

    // Smallest all-ones mask covering total-1, so a masked draw is < 2*total
    function automatic logic [W2-1:0] mask_of(input logic [W2-1:0] t);
        logic [W2-1:0] m;
        m = '0;
        for (int i = 0; i < W2; i++)
            if (m < t - ONE) m = {m[W2-2:0], 1'b1};
        return m;
    endfunction

    // Segment table for the registered request
    always_comb begin
        b_typ  = '0;
        b_from = '0;
        b_to   = '0;
        b_w    = '0;
        case (flag_q)
            2'd0: begin
                b_typ[0] = T_UNI; b_from[0] = MIN_V; b_to[0] = MAX_V;
                b_w[0] = ONE << WIDTH;
            end
            2'd1: begin
                b_typ[0] = T_UNI; b_from[0] = MIN_V; b_to[0] = cl_q;
                b_w[0] = cl_x - min_x + ONE;
                b_typ[1] = T_EXPDOWN; b_from[1] = cl_q; b_to[1] = MAX_V; b_w[1] = EW;
            end
            2'd2: begin
                b_typ[0] = T_EXPUP; b_from[0] = MIN_V; b_to[0] = cm_q; b_w[0] = EW;
                b_typ[1] = T_UNI; b_from[1] = cm_q; b_to[1] = MAX_V;
                b_w[1] = max_x - cm_x + ONE;
            end
            default: begin
                if ($signed(cl_q) >= $signed(cm_q)) begin
                    b_typ[0] = T_EXPUP; b_from[0] = MIN_V; b_to[0] = cm_q; b_w[0] = EW;
                    b_typ[1] = T_UNI; b_from[1] = cm_q; b_to[1] = cl_q;
                    b_w[1] = cl_x - cm_x + ONE;
                    b_typ[2] = T_EXPDOWN; b_from[2] = cl_q; b_to[2] = MAX_V; b_w[2] = EW;
                end else begin
                    // Crossed bounds: split at the midpoint into two tails
                    b_typ[0] = T_EXPUP; b_from[0] = MIN_V; b_to[0] = mid; b_w[0] = EW;
                    b_typ[1] = T_EXPDOWN; b_from[1] = mid; b_to[1] = MAX_V; b_w[1] = EW;
                end
            end
        endcase
        b_total = b_w[0] + b_w[1] + b_w[2];
        b_mask  = mask_of(b_total);
    end

    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    assign r_draw    = lfsr_next[W2-1:0] & mask_q;
    assign cum_next  = cum_q + w_q[idx_q];

    // Control FSM, LFSR and registered result outputs
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state              <= IDLE;
            lfsr               <= (in_seed == '0) ? LFSR_WIDTH'(1) : in_seed;
            cl_q               <= '0;
            cm_q               <= '0;
            flag_q             <= '0;
            typ_q              <= '0;
            from_q             <= '0;
            to_q               <= '0;
            w_q                <= '0;
            total_q            <= '0;
            mask_q             <= '0;
            r_q                <= '0;
            cum_q              <= '0;
            retry_q            <= '0;
            idx_q              <= '0;
            out_start_ready    <= 1'b1;
            out_valid          <= 1'b0;
            out_segment_index  <= '0;
            out_segment_type   <= '0;
            out_segment_from   <= '0;
            out_segment_to     <= '0;
            out_segment_weight <= '0;
            out_total_weight   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_start_valid && out_start_ready) begin
                        cl_q            <= in_c_less_than;
                        cm_q            <= in_c_more_than;
                        flag_q          <= in_flag;
                        out_start_ready <= 1'b0;
                        state           <= BUILD;
                    end
                end
                BUILD: begin
                    typ_q   <= b_typ;
                    from_q  <= b_from;
                    to_q    <= b_to;
                    w_q     <= b_w;
                    total_q <= b_total;
                    mask_q  <= b_mask;
                    retry_q <= '0;
                    state   <= DRAW;
                end
                DRAW: begin
                    lfsr  <= lfsr_next;
                    idx_q <= '0;
                    cum_q <= '0;
                    if (r_draw < total_q) begin
                        r_q   <= r_draw;
                        state <= SCAN;
                    end else if (retry_q == RW'(MAX_RETRY)) begin
                        // mask < 2*total, so one fold lands inside the range
                        r_q   <= r_draw - total_q;
                        state <= SCAN;
                    end else begin
                        retry_q <= retry_q + RW'(1);
                    end
                end
                SCAN: begin
                    if (r_q < cum_next || idx_q == 2'd2) begin
                        out_segment_index  <= idx_q;
                        out_segment_type   <= typ_q[idx_q];
                        out_segment_from   <= from_q[idx_q];
                        out_segment_to     <= to_q[idx_q];
                        out_segment_weight <= w_q[idx_q];
                        out_total_weight   <= total_q;
                        out_valid          <= 1'b1;
                        state              <= DONE;
                    end else begin
                        idx_q <= idx_q + 2'd1;
                        cum_q <= cum_next;
                    end
                end
                DONE: begin
                    if (in_result_ready) begin
                        out_valid       <= 1'b0;
                        out_start_ready <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_segment_select_seq.sv
// Scoreboard bench for segment_select_seq: the expected segment table is
// pushed at request time and checked against each emitted result.
module tb_segment_select_seq;
    localparam int WIDTH = 8;
    localparam int LW    = 16;
    localparam int W2    = WIDTH + 2;
    localparam int MINV  = -(1 << (WIDTH - 1));
    localparam int MAXV  = (1 << (WIDTH - 1)) - 1;
    localparam int EW    = 2;

    logic              in_clock = 1'b0;
    logic              in_reset = 1'b1;
    logic [LW-1:0]     in_seed = 16'hACE1;
    logic              in_start_valid = 1'b0;
    logic              out_start_ready;
    logic [WIDTH-1:0]  in_c_less_than = '0;
    logic [WIDTH-1:0]  in_c_more_than = '0;
    logic [1:0]        in_flag = '0;
    logic              out_valid;
    logic              in_result_ready = 1'b0;
    logic [1:0]        out_segment_index;
    logic [1:0]        out_segment_type;
    logic [WIDTH-1:0]  out_segment_from;
    logic [WIDTH-1:0]  out_segment_to;
    logic [W2-1:0]     out_segment_weight;
    logic [W2-1:0]     out_total_weight;

    always #5 in_clock = ~in_clock;

    segment_select_seq dut (
        .in_clock(in_clock), .in_reset(in_reset), .in_seed(in_seed),
        .in_start_valid(in_start_valid), .out_start_ready(out_start_ready),
        .in_c_less_than(in_c_less_than), .in_c_more_than(in_c_more_than),
        .in_flag(in_flag), .out_valid(out_valid), .in_result_ready(in_result_ready),
        .out_segment_index(out_segment_index), .out_segment_type(out_segment_type),
        .out_segment_from(out_segment_from), .out_segment_to(out_segment_to),
        .out_segment_weight(out_segment_weight), .out_total_weight(out_total_weight)
    );

    typedef struct packed {
        int              n;
        int              total;
        logic [2:0][1:0]  typ;
        logic [2:0][31:0] from_v;
        logic [2:0][31:0] to_v;
        logic [2:0][31:0] w;
    } exp_t;

    exp_t sb[$];
    int   seq_a[$];
    int   seq_b[$];
    int   idx_hist[3];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int flag, input int cl, input int cm);
        exp_t e;
        int   mid;
        e = '0;
        case (flag)
            0: begin
                e.n = 1;
                e.typ[0] = 3; e.from_v[0] = MINV; e.to_v[0] = MAXV; e.w[0] = 1 << WIDTH;
            end
            1: begin
                e.n = 2;
                e.typ[0] = 3; e.from_v[0] = MINV; e.to_v[0] = cl; e.w[0] = cl - MINV + 1;
                e.typ[1] = 1; e.from_v[1] = cl; e.to_v[1] = MAXV; e.w[1] = EW;
            end
            2: begin
                e.n = 2;
                e.typ[0] = 2; e.from_v[0] = MINV; e.to_v[0] = cm; e.w[0] = EW;
                e.typ[1] = 3; e.from_v[1] = cm; e.to_v[1] = MAXV; e.w[1] = MAXV - cm + 1;
            end
            default: begin
                if (cl >= cm) begin
                    e.n = 3;
                    e.typ[0] = 2; e.from_v[0] = MINV; e.to_v[0] = cm; e.w[0] = EW;
                    e.typ[1] = 3; e.from_v[1] = cm; e.to_v[1] = cl; e.w[1] = cl - cm + 1;
                    e.typ[2] = 1; e.from_v[2] = cl; e.to_v[2] = MAXV; e.w[2] = EW;
                end else begin
                    mid = (cl + cm) >>> 1;
                    e.n = 2;
                    e.typ[0] = 2; e.from_v[0] = MINV; e.to_v[0] = mid; e.w[0] = EW;
                    e.typ[1] = 1; e.from_v[1] = mid; e.to_v[1] = MAXV; e.w[1] = EW;
                end
            end
        endcase
        e.total = int'(e.w[0] + e.w[1] + e.w[2]);
        return e;
    endfunction

    // One request: drive, push expectation, wait bounded, pop and compare
    task automatic do_req(input int flag, input int cl, input int cm, input int stall,
                          output int idx);
        exp_t e;
        int   lat;
        int   s_idx, s_from, s_tot;
        idx = -1;
        in_flag = 2'(flag);
        in_c_less_than = WIDTH'(cl);
        in_c_more_than = WIDTH'(cm);
        in_start_valid = 1'b1;
        chk("start_ready_idle", out_start_ready, 1);
        @(posedge in_clock); #1;
        in_start_valid = 1'b0;
        sb.push_back(model(flag, cl, cm));
        lat = 0;
        while (!out_valid && lat < 12) begin
            @(posedge in_clock); #1;
            lat++;
        end
        e = sb.pop_front();
        if (!out_valid) begin
            chk("result_timeout", 0, 1);
            return;
        end
        idx = int'(out_segment_index);
        chk("idx_in_table", idx < e.n, 1);
        if (idx < e.n) begin
            chk("seg_type", out_segment_type, e.typ[idx]);
            chk("seg_from", $signed(out_segment_from), $signed(e.from_v[idx]));
            chk("seg_to", $signed(out_segment_to), $signed(e.to_v[idx]));
            chk("seg_weight", out_segment_weight, e.w[idx]);
            chk("lat_min", lat, (lat >= idx + 3) ? lat : idx + 3);
            chk("lat_max", lat, (lat <= idx + 6) ? lat : idx + 6);
            idx_hist[idx]++;
        end
        chk("total_weight", out_total_weight, e.total);
        s_idx  = int'(out_segment_index);
        s_from = int'(out_segment_from);
        s_tot  = int'(out_total_weight);
        for (int s = 0; s < stall; s++) begin
            @(posedge in_clock); #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_ready", out_start_ready, 0);
            chk("stall_idx", out_segment_index, s_idx);
            chk("stall_from", out_segment_from, s_from);
            chk("stall_total", out_total_weight, s_tot);
        end
        in_result_ready = 1'b1;
        @(posedge in_clock); #1;
        in_result_ready = 1'b0;
        chk("post_valid", out_valid, 0);
        chk("post_ready", out_start_ready, 1);
        chk("post_idx_kept", out_segment_index, s_idx);
    endtask

    task automatic do_reset(input logic [LW-1:0] seed);
        in_seed = seed;
        in_reset = 1'b1;
        in_start_valid = 1'b0;
        in_result_ready = 1'b0;
        repeat (2) @(posedge in_clock);
        #1;
        in_reset = 1'b0;
    endtask

    initial begin
        int k;
        // Reset state
        in_reset = 1'b1;
        repeat (2) @(posedge in_clock);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_start_ready", out_start_ready, 1);
        chk("rst_idx", out_segment_index, 0);
        chk("rst_type", out_segment_type, 0);
        chk("rst_from", out_segment_from, 0);
        chk("rst_to", out_segment_to, 0);
        chk("rst_weight", out_segment_weight, 0);
        chk("rst_total", out_total_weight, 0);
        in_reset = 1'b0;

        // Full-range single segment
        for (int i = 0; i < 8; i++) do_req(0, 0, 0, 0, k);

        // Three segments, frequency of the uniform middle
        idx_hist = '{0, 0, 0};
        for (int i = 0; i < 200; i++) do_req(3, 10, -5, 0, k);
        $display("info: flag3 index counts %0d %0d %0d", idx_hist[0], idx_hist[1], idx_hist[2]);
        chk("idx1_freq_low", idx_hist[1] >= 144, 1);
        chk("idx1_freq_high", idx_hist[1] <= 176, 1);

        // Crossed bounds, boundary bounds, widest totals
        for (int i = 0; i < 20; i++) do_req(3, -20, 30, 0, k);
        for (int i = 0; i < 10; i++) do_req(2, 0, 127, 0, k);
        for (int i = 0; i < 10; i++) do_req(1, -128, 0, 0, k);
        for (int i = 0; i < 6; i++) do_req(1, 127, 0, 0, k);
        for (int i = 0; i < 6; i++) do_req(3, 127, -128, 0, k);
        for (int i = 0; i < 6; i++) do_req(3, -128, 127, 0, k);

        // Consumer stall in DONE
        do_req(3, 10, -5, 10, k);

        // Reset while in DRAW aborts the request
        in_flag = 2'd3; in_c_less_than = 8'd10; in_c_more_than = 8'hFB;
        in_start_valid = 1'b1;
        @(posedge in_clock); #1;
        in_start_valid = 1'b0;
        @(posedge in_clock); #1;
        in_reset = 1'b1;
        @(posedge in_clock); #1;
        in_reset = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_ready", out_start_ready, 1);
        chk("abort_type", out_segment_type, 0);
        chk("abort_total", out_total_weight, 0);
        repeat (10) @(posedge in_clock);
        #1;
        chk("abort_no_result", out_valid, 0);

        // Zero seed
        do_reset('0);
        for (int i = 0; i < 5; i++) do_req(3, 10, -5, 0, k);
        chk("lfsr_nonzero", dut.lfsr != '0, 1);

        // Same seed reproduces the same sequence
        do_reset(16'h1D2B);
        for (int i = 0; i < 24; i++) begin
            do_req(i % 4, 10 - i, -5 + i, 0, k);
            seq_a.push_back(k);
        end
        do_reset(16'h1D2B);
        for (int i = 0; i < 24; i++) begin
            do_req(i % 4, 10 - i, -5 + i, 0, k);
            seq_b.push_back(k);
        end
        for (int i = 0; i < 24; i++) chk("repro_seq", seq_b[i], seq_a[i]);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
